bmu_modport: RTL and testbench
==============================

Name: bmu_modport

Overview:
- Single-cycle RV32 bit-manipulation unit (Zba/Zbb-style operations plus logic, shift, compare and CSR data path).
- Sits in the execute stage: decoded one-hot op controls and operands go in; one registered 32-bit result and an error flag come out.
- Results are available the cycle after the operation is issued.

Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clk  in  1  clock, rising-edge
- rst_l  in  1  asynchronous reset, active-high; despite the _l name, 1 = reset
- a_in  in  32  operand A (rs1)
- b_in  in  32  operand B (rs2 or immediate)
- scan_mode  in  1  DFT scan enable; no functional effect
- valid_in  in  1  operation issue qualifier
- csr_ren_in  in  1  CSR read: return csr_rddata_in
- csr_rddata_in  in  32  CSR read data
- ap_land, ap_lor, ap_lxor  in  1 each  logical and / or / xor
- ap_zbb  in  1  modifier: invert b for land/lor/lxor
- ap_srl, ap_sra, ap_ror, ap_rol  in  1 each  shift/rotate right-logical / right-arith / rotate-right / rotate-left
- ap_binv  in  1  single-bit invert
- ap_sh1add, ap_sh2add, ap_sh3add  in  1 each  shift-and-add
- ap_zba  in  1  required qualifier for shNadd
- ap_sub, ap_slt  in  1 each  subtract / set-less-than
- ap_unsign  in  1  modifier: unsigned compare for slt/max/min
- ap_ctz, ap_clz, ap_cpop  in  1 each  count trailing zeros / leading zeros / ones
- ap_siext_b, ap_siext_h  in  1 each  sign-extend byte / halfword
- ap_max, ap_min  in  1 each  maximum / minimum
- ap_pack  in  1  pack halves
- ap_grev  in  1  generalized reverse
- ap_csr_write  in  1  CSR write-data pass-through
- ap_csr_imm  in  1  CSR write uses immediate (b_in) instead of a_in
- result_ff  out  32  registered result
- error  out  1  registered illegal-op flag

Behaviour:
- Reset (async, rst_l=1): result_ff=0, error=0 immediately. Both stay 0 while rst_l=1.
- Latency: sample on posedge with valid_in=1; result_ff and error update at that edge and are visible the following cycle.
- valid_in=0: result_ff holds its previous value; error is cleared to 0.
- Shift amount is sh=b_in[4:0]. All arithmetic is modulo 2^32.
- Primary ops (exactly one must be set when valid_in=1): land, lor, lxor, srl, sra, ror, rol, binv, sh1add, sh2add, sh3add, sub, slt, ctz, clz, cpop, siext_b, siext_h, max, min, pack, grev, csr_write.
- Exception to the one-primary-op rule: csr_ren_in=1 with no primary op is a legal CSR read.
- Logical ops: land = a&b, lor = a|b, lxor = a^b.
  - With ap_zbb=1 these become a&~b, a|~b, ~(a^b).
- Shifts and rotates:
  - srl = a>>sh (logical).
  - sra = $signed(a)>>>sh.
  - ror / rol = rotate a right / left by sh; sh=0 returns a.
- binv = a ^ (1<<sh).
- shNadd = (a<<N)+b, for N=1,2,3. Requires ap_zba=1.
- sub = a-b.
- slt = {31'b0, a<b}. Compare is signed unless ap_unsign=1.
- max / min: signed unless ap_unsign=1.
- Counts operate on a:
  - ctz / clz return 0..32; an input of 0 returns 32.
  - cpop returns the number of 1 bits.
- siext_b = sign-extended a[7:0]; siext_h = sign-extended a[15:0].
- pack = {b[15:0], a[15:0]}.
- grev: staged swaps on a. If sh[k]=1, swap adjacent 2^k-bit groups, for k=0..4.
  - sh=24 gives byte reverse (rev8); sh=31 gives full bit reverse.
- csr_write: result = ap_csr_imm ? b_in : a_in.
- csr_ren_in=1 (with or without csr_write): result = csr_rddata_in. The read has priority over write data.
- Error conditions (only evaluated when valid_in=1):
  - zero primary ops without csr_ren_in;
  - more than one primary op;
  - any shNadd with ap_zba=0;
  - ap_zba=1 without a shNadd;
  - ap_zbb=1 with an op other than land/lor/lxor;
  - ap_unsign=1 with an op other than slt/max/min.
- On error: result_ff <= 0 and error <= 1 for that cycle.
- Ignored modifiers:
  - ap_csr_imm is ignored unless csr_write is set.
  - scan_mode is fully ignored.

Test Plan:
- Reset mid-operation: assert rst_l=1 asynchronously while result_ff=0x1234 -> result_ff=0 and error=0 without waiting for a clock edge.
- Logic with zbb: a=0xF0F0F0F0, b=0x0FF00FF0.
  - land -> 0x00F000F0.
  - land+zbb -> 0xF000F000.
  - lxor+zbb -> 0x00FF00FF.
- Shifts: a=0x80000001, b=4.
  - sra -> 0xF8000000.
  - srl -> 0x08000000.
  - ror -> 0x18000000.
  - rol -> 0x00000018.
- Zba: a=3, b=100.
  - sh3add+zba -> 124.
  - sh3add without zba -> error=1, result_ff=0.
- Counts and compares:
  - ctz(0)=32, clz(1)=31, cpop(0xFF00FF00)=16.
  - a=0xFFFFFFFF, b=1: max=1; max+unsign=0xFFFFFFFF; slt=1; slt+unsign=0.
- Misc and CSR:
  - grev with b=24 on a=0x11223344 -> 0x44332211.
  - pack with a=0xAAAA1111, b=0xBBBB2222 -> 0x22221111.
  - csr_ren_in with rddata=0xDEAD -> 0xDEAD.
  - csr_write+imm with b=5 -> 5.
  - land+lor together -> error=1.

Source files
------------

// File: rtl/bmu_modport.sv
// Single-cycle RV32 bit-manipulation unit: logic, shift, Zba/Zbb and CSR data path.
// One registered 32-bit result plus an illegal-op flag, valid the cycle after issue.
module bmu_modport (
   input  logic        clk,
   input  logic        rst_l,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        scan_mode,
   input  logic        valid_in,
   input  logic        csr_ren_in,
   input  logic [31:0] csr_rddata_in,
   input  logic        ap_land,
   input  logic        ap_lor,
   input  logic        ap_lxor,
   input  logic        ap_zbb,
   input  logic        ap_srl,
   input  logic        ap_sra,
   input  logic        ap_ror,
   input  logic        ap_rol,
   input  logic        ap_binv,
   input  logic        ap_sh1add,
   input  logic        ap_sh2add,
   input  logic        ap_sh3add,
   input  logic        ap_zba,
   input  logic        ap_sub,
   input  logic        ap_slt,
   input  logic        ap_unsign,
   input  logic        ap_ctz,
   input  logic        ap_clz,
   input  logic        ap_cpop,
   input  logic        ap_siext_b,
   input  logic        ap_siext_h,
   input  logic        ap_max,
   input  logic        ap_min,
   input  logic        ap_pack,
   input  logic        ap_grev,
   input  logic        ap_csr_write,
   input  logic        ap_csr_imm,
   output logic [31:0] result_ff,
   output logic        error
);

   logic [31:0] result_q, result_d;
   logic        error_q, error_d;

   logic        unused_scan;
   assign unused_scan = scan_mode;

   logic [22:0] prim;
   logic [4:0]  prim_cnt;
   logic        sh_add, logic_op, cmp_op, err;

   logic [4:0]  sh;
   logic [31:0] bm, sra_r, ror_r, rol_r, grev_r, sub_r;
   logic [63:0] dbl;
   logic        lt;
   logic [5:0]  ctz_r, clz_r, cpop_r;
   logic        ctz_f, clz_f;
   logic [31:0] res;

   assign sh = b_in[4:0];

   assign prim = {ap_land, ap_lor, ap_lxor, ap_srl, ap_sra, ap_ror,
                  ap_rol, ap_binv, ap_sh1add, ap_sh2add, ap_sh3add,
                  ap_sub, ap_slt, ap_ctz, ap_clz, ap_cpop, ap_siext_b,
                  ap_siext_h, ap_max, ap_min, ap_pack, ap_grev,
                  ap_csr_write};

   assign sh_add   = ap_sh1add | ap_sh2add | ap_sh3add;
   assign logic_op = ap_land | ap_lor | ap_lxor;
   assign cmp_op   = ap_slt | ap_max | ap_min;

   always_comb begin
      prim_cnt = 5'd0;
      for (int i = 0; i < 23; i++) prim_cnt = prim_cnt + {4'd0, prim[i]};
   end

   assign err = ((prim_cnt == 5'd0) & ~csr_ren_in) |
                (prim_cnt > 5'd1) |
                (sh_add & ~ap_zba) | (ap_zba & ~sh_add) |
                (ap_zbb & ~logic_op) | (ap_unsign & ~cmp_op);

   // ~(a^b) equals a^~b, so all three logical ops share the inverted operand
   assign bm    = ap_zbb ? ~b_in : b_in;
   assign sra_r = $signed(a_in) >>> sh;
   assign dbl   = {a_in, a_in};
   assign ror_r = 32'(dbl >> sh);
   assign rol_r = 32'((dbl << sh) >> 32);
   assign sub_r = a_in - b_in;
   assign lt    = ap_unsign ? (a_in < b_in)
                            : ($signed(a_in) < $signed(b_in));

   always_comb begin
      grev_r = a_in;
      if (sh[0]) grev_r = ((grev_r & 32'h5555_5555) << 1)
                        | ((grev_r & 32'hAAAA_AAAA) >> 1);
      if (sh[1]) grev_r = ((grev_r & 32'h3333_3333) << 2)
                        | ((grev_r & 32'hCCCC_CCCC) >> 2);
      if (sh[2]) grev_r = ((grev_r & 32'h0F0F_0F0F) << 4)
                        | ((grev_r & 32'hF0F0_F0F0) >> 4);
      if (sh[3]) grev_r = ((grev_r & 32'h00FF_00FF) << 8)
                        | ((grev_r & 32'hFF00_FF00) >> 8);
      if (sh[4]) grev_r = ((grev_r & 32'h0000_FFFF) << 16)
                        | ((grev_r & 32'hFFFF_0000) >> 16);
   end

   always_comb begin
      ctz_r  = 6'd32;
      clz_r  = 6'd32;
      cpop_r = 6'd0;
      ctz_f  = 1'b0;
      clz_f  = 1'b0;
      for (int i = 0; i < 32; i++) begin
         cpop_r = cpop_r + {5'd0, a_in[i]};
         if (!ctz_f && a_in[i]) begin
            ctz_r = 6'(i);
            ctz_f = 1'b1;
         end
         if (!clz_f && a_in[31-i]) begin
            clz_r = 6'(i);
            clz_f = 1'b1;
         end
      end
   end

   // AND-OR mux: one-hot in legal use, and overlaps are masked by err
   always_comb begin
      res = ({32{ap_land}}    & (a_in & bm))
          | ({32{ap_lor}}     & (a_in | bm))
          | ({32{ap_lxor}}    & (a_in ^ bm))
          | ({32{ap_srl}}     & (a_in >> sh))
          | ({32{ap_sra}}     & sra_r)
          | ({32{ap_ror}}     & ror_r)
          | ({32{ap_rol}}     & rol_r)
          | ({32{ap_binv}}    & (a_in ^ (32'd1 << sh)))
          | ({32{ap_sh1add}}  & ((a_in << 1) + b_in))
          | ({32{ap_sh2add}}  & ((a_in << 2) + b_in))
          | ({32{ap_sh3add}}  & ((a_in << 3) + b_in))
          | ({32{ap_sub}}     & sub_r)
          | ({32{ap_slt}}     & {31'd0, lt})
          | ({32{ap_ctz}}     & {26'd0, ctz_r})
          | ({32{ap_clz}}     & {26'd0, clz_r})
          | ({32{ap_cpop}}    & {26'd0, cpop_r})
          | ({32{ap_siext_b}} & {{24{a_in[7]}}, a_in[7:0]})
          | ({32{ap_siext_h}} & {{16{a_in[15]}}, a_in[15:0]})
          | ({32{ap_max}}     & (lt ? b_in : a_in))
          | ({32{ap_min}}     & (lt ? a_in : b_in))
          | ({32{ap_pack}}    & {b_in[15:0], a_in[15:0]})
          | ({32{ap_grev}}    & grev_r)
          | ({32{ap_csr_write}} & (ap_csr_imm ? b_in : a_in));
      if (csr_ren_in) res = csr_rddata_in;
   end

   always_comb begin
      result_d = result_q;
      error_d  = 1'b0;
      if (valid_in) begin
         if (err) begin
            result_d = 32'd0;
            error_d  = 1'b1;
         end else begin
            result_d = res;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_l) begin
      if (rst_l) begin
         result_q <= 32'd0;
         error_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   assign result_ff = result_q;
   assign error     = error_q;

endmodule

// File: tb/tb_bmu_modport.sv
// Table-driven bench for bmu_modport with an expected-result queue,
// plus hand-written reset and hold sequences.
module tb_bmu_modport;

   localparam int P_LAND = 22, P_LOR = 21, P_LXOR = 20, P_SRL = 19;
   localparam int P_SRA = 18, P_ROR = 17, P_ROL = 16, P_BINV = 15;
   localparam int P_SH1 = 14, P_SH2 = 13, P_SH3 = 12, P_SUB = 11;
   localparam int P_SLT = 10, P_CTZ = 9, P_CLZ = 8, P_CPOP = 7;
   localparam int P_SEB = 6, P_SEH = 5, P_MAX = 4, P_MIN = 3;
   localparam int P_PACK = 2, P_GREV = 1, P_CSRW = 0;

   localparam logic [4:0] F_NONE = 5'b00000, F_ZBB = 5'b10000;
   localparam logic [4:0] F_ZBA = 5'b01000, F_UNS = 5'b00100;
   localparam logic [4:0] F_IMM = 5'b00010, F_REN = 5'b00001;

   typedef struct {
      logic [22:0] ops;
      logic [4:0]  flg;
      logic [31:0] a, b, rd;
      logic [31:0] exp_r;
      logic        exp_e;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic        e;
   } exp_t;

   logic clk = 1'b0, rst_l = 1'b1;
   logic [31:0] a_in = '0, b_in = '0, csr_rddata_in = '0;
   logic scan_mode = 1'b0, valid_in = 1'b0;
   logic [22:0] ops = '0;
   logic [4:0] flg = '0;
   logic [31:0] result_ff;
   logic error;

   int n_vec = 0, n_bad = 0;
   vec_t vq[$];
   exp_t sbq[$];

   always #5 clk = ~clk;

   bmu_modport dut (
      .clk(clk), .rst_l(rst_l), .a_in(a_in), .b_in(b_in),
      .scan_mode(scan_mode), .valid_in(valid_in),
      .csr_ren_in(flg[0]), .csr_rddata_in(csr_rddata_in),
      .ap_land(ops[P_LAND]), .ap_lor(ops[P_LOR]), .ap_lxor(ops[P_LXOR]),
      .ap_zbb(flg[4]), .ap_srl(ops[P_SRL]), .ap_sra(ops[P_SRA]),
      .ap_ror(ops[P_ROR]), .ap_rol(ops[P_ROL]), .ap_binv(ops[P_BINV]),
      .ap_sh1add(ops[P_SH1]), .ap_sh2add(ops[P_SH2]),
      .ap_sh3add(ops[P_SH3]), .ap_zba(flg[3]), .ap_sub(ops[P_SUB]),
      .ap_slt(ops[P_SLT]), .ap_unsign(flg[2]), .ap_ctz(ops[P_CTZ]),
      .ap_clz(ops[P_CLZ]), .ap_cpop(ops[P_CPOP]),
      .ap_siext_b(ops[P_SEB]), .ap_siext_h(ops[P_SEH]),
      .ap_max(ops[P_MAX]), .ap_min(ops[P_MIN]), .ap_pack(ops[P_PACK]),
      .ap_grev(ops[P_GREV]), .ap_csr_write(ops[P_CSRW]),
      .ap_csr_imm(flg[1]), .result_ff(result_ff), .error(error)
   );

   function automatic logic [22:0] op(input int p);
      return 23'd1 << p;
   endfunction

   function automatic vec_t mk(input logic [22:0] o, input logic [4:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] rd,
                               input logic [31:0] er, input logic ee);
      vec_t v;
      v.ops = o; v.flg = f; v.a = a; v.b = b; v.rd = rd;
      v.exp_r = er; v.exp_e = ee;
      return v;
   endfunction

   task automatic check(input string tag);
      exp_t x;
      if (sbq.size() == 0) begin
         n_vec++; n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      x = sbq.pop_front();
      n_vec++;
      if (result_ff !== x.r || error !== x.e) begin
         n_bad++;
         $display("FAIL %s: got result=%h error=%b, want result=%h error=%b",
                  tag, result_ff, error, x.r, x.e);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag, input logic vld);
      exp_t x;
      @(negedge clk);
      ops = v.ops; flg = v.flg; a_in = v.a; b_in = v.b;
      csr_rddata_in = v.rd; valid_in = vld;
      scan_mode = $urandom_range(0, 1) != 0;
      x.r = v.exp_r; x.e = v.exp_e;
      sbq.push_back(x);
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin
      exp_t x;
      vq.push_back(mk(op(P_LAND), F_NONE, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 0));
      vq.push_back(mk(op(P_LAND), F_ZBB, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hF000F000, 0));
      vq.push_back(mk(op(P_LXOR), F_ZBB, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00FF00FF, 0));
      vq.push_back(mk(op(P_LOR), F_NONE, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFFF0FFF0, 0));
      vq.push_back(mk(op(P_SRA), F_NONE, 32'h80000001, 4, 0, 32'hF8000000, 0));
      vq.push_back(mk(op(P_SRL), F_NONE, 32'h80000001, 4, 0, 32'h08000000, 0));
      vq.push_back(mk(op(P_ROR), F_NONE, 32'h80000001, 4, 0, 32'h18000000, 0));
      vq.push_back(mk(op(P_ROL), F_NONE, 32'h80000001, 4, 0, 32'h00000018, 0));
      vq.push_back(mk(op(P_ROR), F_NONE, 32'h12345678, 0, 0, 32'h12345678, 0));
      vq.push_back(mk(op(P_ROL), F_NONE, 32'h000000A5, 32, 0, 32'h000000A5, 0));
      vq.push_back(mk(op(P_SH3), F_ZBA, 3, 100, 0, 124, 0));
      vq.push_back(mk(op(P_SH3), F_NONE, 3, 100, 0, 0, 1));
      vq.push_back(mk(op(P_SH1), F_ZBA, 32'h80000000, 1, 0, 1, 0));
      vq.push_back(mk(op(P_CTZ), F_NONE, 0, 0, 0, 32, 0));
      vq.push_back(mk(op(P_CTZ), F_NONE, 32'h80000000, 0, 0, 31, 0));
      vq.push_back(mk(op(P_CLZ), F_NONE, 1, 0, 0, 31, 0));
      vq.push_back(mk(op(P_CLZ), F_NONE, 0, 0, 0, 32, 0));
      vq.push_back(mk(op(P_CPOP), F_NONE, 32'hFF00FF00, 0, 0, 16, 0));
      vq.push_back(mk(op(P_MAX), F_NONE, 32'hFFFFFFFF, 1, 0, 1, 0));
      vq.push_back(mk(op(P_MAX), F_UNS, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0));
      vq.push_back(mk(op(P_MIN), F_UNS, 32'hFFFFFFFF, 1, 0, 1, 0));
      vq.push_back(mk(op(P_SLT), F_NONE, 32'hFFFFFFFF, 1, 0, 1, 0));
      vq.push_back(mk(op(P_SLT), F_UNS, 32'hFFFFFFFF, 1, 0, 0, 0));
      vq.push_back(mk(op(P_GREV), F_NONE, 32'h11223344, 24, 0, 32'h44332211, 0));
      vq.push_back(mk(op(P_GREV), F_NONE, 1, 31, 0, 32'h80000000, 0));
      vq.push_back(mk(op(P_PACK), F_NONE, 32'hAAAA1111, 32'hBBBB2222, 0, 32'h22221111, 0));
      vq.push_back(mk('0, F_REN, 1, 2, 32'h0000DEAD, 32'h0000DEAD, 0));
      vq.push_back(mk(op(P_CSRW), F_IMM, 32'h77, 5, 0, 5, 0));
      vq.push_back(mk(op(P_CSRW), F_NONE, 32'h77, 5, 0, 32'h77, 0));
      vq.push_back(mk(op(P_CSRW), F_REN | F_IMM, 1, 5, 32'hBEEF, 32'hBEEF, 0));
      vq.push_back(mk(op(P_LAND) | op(P_LOR), F_NONE, 32'hFF, 32'hF, 0, 0, 1));
      vq.push_back(mk(op(P_BINV), F_NONE, 0, 31, 0, 32'h80000000, 0));
      vq.push_back(mk(op(P_SUB), F_NONE, 5, 7, 0, 32'hFFFFFFFE, 0));
      vq.push_back(mk(op(P_SEB), F_NONE, 32'h80, 0, 0, 32'hFFFFFF80, 0));
      vq.push_back(mk(op(P_SEH), F_NONE, 32'h1234, 0, 0, 32'h00001234, 0));
      vq.push_back(mk('0, F_NONE, 5, 5, 0, 0, 1));
      vq.push_back(mk(op(P_LAND), F_UNS, 5, 5, 0, 0, 1));
      vq.push_back(mk(op(P_LAND), F_ZBA, 5, 5, 0, 0, 1));
      vq.push_back(mk(op(P_SUB), F_ZBB, 5, 5, 0, 0, 1));

      // reset held across clock edges with a live operation
      ops = op(P_CSRW); a_in = 32'h55; valid_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      x.r = 0; x.e = 0; sbq.push_back(x);
      check("reset_hold");
      @(negedge clk);
      rst_l = 1'b0;

      foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i), 1'b1);

      // valid_in low holds result and clears error
      run_vec(mk(op(P_CSRW), F_NONE, 32'h1234, 0, 0, 32'h1234, 0), "load_1234", 1'b1);
      run_vec(mk(op(P_LAND), F_NONE, 32'hFFFF, 32'hF, 0, 32'h1234, 0), "hold_idle", 1'b0);
      run_vec(mk(op(P_SH2), F_NONE, 1, 1, 0, 0, 1), "err_set", 1'b1);
      run_vec(mk(op(P_SH2), F_NONE, 1, 1, 0, 0, 0), "err_clear", 1'b0);

      // asynchronous reset between clock edges
      run_vec(mk(op(P_CSRW), F_NONE, 32'h1234, 0, 0, 32'h1234, 0), "pre_reset", 1'b1);
      @(negedge clk);
      #2 rst_l = 1'b1;
      #1;
      x.r = 0; x.e = 0; sbq.push_back(x);
      check("async_reset");
      @(negedge clk);
      rst_l = 1'b0;
      run_vec(mk(op(P_SH2), F_ZBA, 2, 3, 0, 11, 0), "post_reset", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
